control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL provide parameter MEM_TIMEOUT, default 16, meaning the number of wait cycles without ready before a memory request traps (legal range 2..255).
REQ-002 SHALL provide parameter INSTRET_W, default 32, meaning the width of the retired-instruction counter.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 instruction  input  32  current instruction word, held stable by the external IR from the ir_load pulse until the next ir_load.
REQ-006 zero  input  1  ALU zero flag from the datapath.
REQ-007 imem_ready  input  1  instruction memory accepts the request and returns the word this cycle.
REQ-008 dmem_ready  input  1  data memory completes the current access this cycle.
REQ-009 imem_req  output  1  instruction fetch request.
REQ-010 dmem_req, dmem_we  output  1 each  data access request; write enable, valid only with dmem_req.
REQ-011 ir_load  output  1  one-cycle strobe that loads the fetched word into the IR.
REQ-012 pc_en  output  1  one-cycle strobe that updates the PC (next PC is pc+4, or pc+(imm<<1) when PCSrc=1).
REQ-013 RegWrite, MemtoReg, ALUSrc, PCSrc  output  1 each  datapath controls.
REQ-014 ALUOp  output  4  ALU function: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
REQ-015 halted  output  1  sticky trap indicator; trap_cause  output  2: 00 none, 01 illegal instruction, 10 imem timeout, 11 dmem timeout.
REQ-016 instret  output  INSTRET_W  count of retired instructions.

Function
REQ-017 SHALL be a Moore FSM with states FETCH, DECODE, EXEC, MEM, WB, TRAP; all outputs decode from state plus latched instruction fields.
REQ-018 FETCH: imem_req=1 until imem_ready; on the imem_ready cycle ir_load=1, then go to DECODE.
REQ-019 DECODE: opcodes 0110011 (R), 0000011 (ld, funct3 011), 0100011 (sd, funct3 011), 1100011 (beq, funct3 000) go to EXEC; any other opcode or funct3 goes to TRAP with cause 01.
REQ-020 R-type ALUOp: funct3 000/funct7 0000000 -> 0010; funct3 000/funct7 0100000 -> 0110; funct3 111 -> 0000; funct3 110 -> 0001; any other combination is illegal.
REQ-021 EXEC: ld/sd drive ALUSrc=1, ALUOp=0010 and go to MEM; R-type drives ALUSrc=0 and go to WB; beq drives ALUSrc=0, ALUOp=0110, PCSrc=zero, pc_en=1, retires, and goes to FETCH.
REQ-022 MEM: dmem_req=1 (dmem_we=1 for sd) until dmem_ready; ALUSrc/ALUOp held from EXEC; ld goes to WB; sd asserts pc_en=1, retires, and goes to FETCH.
REQ-023 WB: RegWrite=1, MemtoReg=1 for ld (else 0), ALUOp/ALUSrc held, pc_en=1, retire, then go to FETCH.
REQ-024 Latency: R-type 4 cycles, ld 5, sd 4, beq 3, each plus memory wait cycles.
REQ-025 Wait counter counts consecutive cycles in FETCH/MEM with req high and ready low; reaching MEM_TIMEOUT goes to TRAP with cause 10 (FETCH) or 11 (MEM).
REQ-026 When ready and the timeout coincide in the same cycle, ready wins and no trap is taken; the counter clears on every state change.
REQ-027 TRAP: all request, strobe and control outputs are 0; halted=1; the state is held until reset.
REQ-028 instret increments by 1 on each pc_en and wraps modulo 2^INSTRET_W.
REQ-029 pc_en, ir_load and RegWrite SHALL each be high for at most one cycle per instruction.

Reset
REQ-030 Reset SHALL take effect asynchronously: the state goes to FETCH and the wait counter, instret, halted and trap_cause clear to 0.
REQ-031 While reset is high, all outputs SHALL be 0; a request in flight is abandoned; imem_req rises in the first cycle after reset deasserts.

Configuration
REQ-032 Macro CTRL_BNE_EN: when defined, branch funct3 001 (bne) is legal and drives PCSrc=~zero in EXEC; when undefined, funct3 001 traps with cause 01.

Structure
REQ-033 A shared package ctrl_pkg SHALL hold the state enum, opcode constants, ALUOp codes and trap_cause codes.
REQ-034 One sub-module, ctrl_decode (combinational opcode/funct decode producing instruction class, ALUOp and illegal flag), SHALL be instantiated; the FSM stays in control_sequencer.

Verification
REQ-035 add x3,x1,x2 (0x002081B3) with imem_ready immediate -> RegWrite=1 in cycle 4, ALUOp=0010, pc_en=1, instret=1.
REQ-036 ld (opcode 0000011, funct3 011), dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, then WB with MemtoReg=1, total 8 cycles.
REQ-037 beq with zero=1 -> PCSrc=1 and pc_en=1 in cycle 3; with zero=0 -> PCSrc=0.
REQ-038 imem_ready held low -> after 16 cycles halted=1, trap_cause=10; a ready arriving exactly on cycle 16 -> no trap.
REQ-039 instruction 0x0000107F (illegal opcode) -> TRAP, cause 01; bne -> taken only with CTRL_BNE_EN defined, otherwise cause 01.
REQ-040 reset asserted mid-MEM -> dmem_req drops immediately, instret=0, restart in FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer:
// FSM states, instruction classes, opcode/funct constants, ALU codes, trap causes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    INS_R,
    INS_LD,
    INS_SD,
    INS_BEQ,
    INS_BNE
  } ins_class_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_IMEM_TO = 2'b10,
    CAUSE_DMEM_TO = 2'b11
  } trap_cause_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_DW     = 3'b011;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: class, ALU function and illegal flag.
// bne is recognised only when CTRL_BNE_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ins_class_t ins_class,
  output logic [3:0] alu_op,
  output logic       illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    ins_class = INS_R;
    alu_op    = ALU_ADD;
    illegal   = 1'b0;
    case (opcode)
      OP_R: begin
        ins_class = INS_R;
        if (funct3 == F3_ADDSUB && funct7 == F7_ADD)      alu_op = ALU_ADD;
        else if (funct3 == F3_ADDSUB && funct7 == F7_SUB) alu_op = ALU_SUB;
        else if (funct3 == F3_AND)                        alu_op = ALU_AND;
        else if (funct3 == F3_OR)                         alu_op = ALU_OR;
        else                                              illegal = 1'b1;
      end
      OP_LD: begin
        ins_class = INS_LD;
        illegal   = (funct3 != F3_DW);
      end
      OP_SD: begin
        ins_class = INS_SD;
        illegal   = (funct3 != F3_DW);
      end
      OP_BR: begin
        alu_op = ALU_SUB;
        if (funct3 == F3_BEQ) ins_class = INS_BEQ;
`ifdef CTRL_BNE_EN
        else if (funct3 == F3_BNE) ins_class = INS_BNE;
`endif
        else illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle Moore control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with memory
// wait timeouts and a retired-instruction counter. Optional: CTRL_BNE_EN.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instruction,
  input  logic                 zero,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 ir_load,
  output logic                 pc_en,
  output logic                 RegWrite,
  output logic                 MemtoReg,
  output logic                 ALUSrc,
  output logic                 PCSrc,
  output logic [3:0]           ALUOp,
  output logic                 halted,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t               state, state_nxt;
  trap_cause_t          cause_q, cause_nxt;
  ins_class_t           cls_q, dec_class;
  logic [3:0]           alu_op_q, dec_alu_op;
  logic                 dec_illegal;
  logic [7:0]           wait_cnt;
  logic [INSTRET_W-1:0] instret_q;
  logic                 waiting, timeout;
  logic                 unused_fields;

  assign unused_fields = ^{instruction[24:15], instruction[11:7]};

  ctrl_decode u_decode (
    .opcode    (instruction[6:0]),
    .funct3    (instruction[14:12]),
    .funct7    (instruction[31:25]),
    .ins_class (dec_class),
    .alu_op    (dec_alu_op),
    .illegal   (dec_illegal)
  );

  assign waiting = (state == ST_FETCH && !imem_ready) || (state == ST_MEM && !dmem_ready);
  assign timeout = waiting && (wait_cnt == WAIT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_FETCH;
      cause_q   <= CAUSE_NONE;
      wait_cnt  <= '0;
      instret_q <= '0;
      cls_q     <= INS_R;
      alu_op_q  <= ALU_ADD;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
      if (pc_en) instret_q <= instret_q + INSTRET_W'(1);
      if (state_nxt != state) wait_cnt <= '0;
      else if (waiting)       wait_cnt <= wait_cnt + 8'd1;
      if (state == ST_DECODE) begin
        cls_q    <= dec_class;
        alu_op_q <= dec_alu_op;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cause_nxt = cause_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_load   = 1'b0;
    pc_en     = 1'b0;
    RegWrite  = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrc    = 1'b0;
    PCSrc     = 1'b0;
    ALUOp     = ALU_AND;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load   = 1'b1;
          state_nxt = ST_DECODE;
        end else if (timeout) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_IMEM_TO;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          INS_LD, INS_SD: begin
            ALUSrc    = 1'b1;
            ALUOp     = ALU_ADD;
            state_nxt = ST_MEM;
          end
          INS_BEQ, INS_BNE: begin
            ALUOp     = ALU_SUB;
            PCSrc     = (cls_q == INS_BEQ) ? zero : ~zero;
            pc_en     = 1'b1;
            state_nxt = ST_FETCH;
          end
          default: begin
            ALUOp     = alu_op_q;
            state_nxt = ST_WB;
          end
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == INS_SD);
        ALUSrc   = 1'b1;
        ALUOp    = ALU_ADD;
        if (dmem_ready) begin
          if (cls_q == INS_SD) begin
            pc_en     = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_WB;
          end
        end else if (timeout) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_DMEM_TO;
        end
      end
      ST_WB: begin
        RegWrite  = 1'b1;
        MemtoReg  = (cls_q == INS_LD);
        ALUSrc    = (cls_q == INS_LD);
        ALUOp     = (cls_q == INS_LD) ? ALU_ADD : alu_op_q;
        pc_en     = 1'b1;
        state_nxt = ST_FETCH;
      end
      default: ;
    endcase
    // Reset forces every output low immediately, even while the state register is FETCH.
    if (reset) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_load  = 1'b0;
      pc_en    = 1'b0;
      RegWrite = 1'b0;
      MemtoReg = 1'b0;
      ALUSrc   = 1'b0;
      PCSrc    = 1'b0;
      ALUOp    = ALU_AND;
    end
  end

  assign halted     = (state == ST_TRAP) && !reset;
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-instruction latency, controls,
// memory waits, timeouts, illegal traps and asynchronous reset.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction = 32'h0;
  logic [31:0] imem_word;
  logic        zero, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, dmem_we, ir_load, pc_en;
  logic        RegWrite, MemtoReg, ALUSrc, PCSrc, halted;
  logic [3:0]  ALUOp;
  logic [1:0]  trap_cause;
  logic [31:0] instret;
  logic [15:0] all_out;

  int total = 0;
  int bad   = 0;
  int exp_instret = 0;

  typedef struct {
    int         cycles;
    int         dreq;
    int         rw_at;
    logic [3:0] op;
    logic       src;
    logic       m2r;
    logic       we;
    logic       pcsrc;
    logic       halt;
    logic [1:0] cause;
  } res_t;

  always #5 clk = ~clk;

  // External IR: captures the fetched word on the ir_load strobe.
  always @(posedge clk) if (ir_load) instruction <= imem_word;

  assign all_out = {imem_req, dmem_req, dmem_we, ir_load, pc_en, RegWrite, MemtoReg,
                    ALUSrc, PCSrc, ALUOp, halted, trap_cause};

  control_sequencer #(.MEM_TIMEOUT(16), .INSTRET_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .zero        (zero),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .ir_load     (ir_load),
    .pc_en       (pc_en),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg),
    .ALUSrc      (ALUSrc),
    .PCSrc       (PCSrc),
    .ALUOp       (ALUOp),
    .halted      (halted),
    .trap_cause  (trap_cause),
    .instret     (instret)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs one instruction from FETCH; memories answer after iwait/dwait stalled cycles.
  task automatic run(input logic [31:0] word, input int iwait, input int dwait,
                     input logic zv, output res_t r);
    int icnt = 0;
    int dcnt = 0;
    bit done = 0;
    r = '{default: 0};
    imem_word = word;
    zero = zv;
    for (int c = 1; c <= 64 && !done; c++) begin
      #1;
      imem_ready = imem_req && (icnt == iwait);
      if (imem_req) icnt++;
      dmem_ready = dmem_req && (dcnt == dwait);
      if (dmem_req) dcnt++;
      @(negedge clk);
      if (RegWrite) r.rw_at = c;
      if (dmem_req) r.dreq++;
      if (dmem_we)  r.we = 1'b1;
      if (pc_en) begin
        r.cycles = c; r.op = ALUOp; r.src = ALUSrc; r.m2r = MemtoReg; r.pcsrc = PCSrc;
        done = 1;
      end else if (halted) begin
        r.cycles = c; r.halt = 1'b1; r.cause = trap_cause;
        done = 1;
      end
      @(posedge clk);
    end
    #1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    check("run_completed", 32'(done), 32'd1);
    if (!r.halt) exp_instret++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    exp_instret = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    reset = 1'b1; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; imem_word = '0;
    #2;
    check("reset_outputs", 32'(all_out), 32'h0);
    check("reset_instret", instret, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("first_cycle_imem_req", 32'(imem_req), 32'd1);

    // add x3,x1,x2
    run(32'h002081B3, 0, 0, 1'b0, r);
    check("add_cycles", r.cycles, 4);
    check("add_regwrite_cycle", r.rw_at, 4);
    check("add_aluop", 32'(r.op), 32'h2);
    check("add_alusrc", 32'(r.src), 32'd0);
    check("add_instret", instret, 32'(exp_instret));

    run(32'h402081B3, 0, 0, 1'b0, r);
    check("sub_aluop", 32'(r.op), 32'h6);
    run(32'h0020F1B3, 0, 0, 1'b0, r);
    check("and_aluop", 32'(r.op), 32'h0);
    run(32'h0020E1B3, 0, 0, 1'b0, r);
    check("or_aluop", 32'(r.op), 32'h1);

    // ld with data memory ready after 3 stalled cycles
    run(32'h0000B183, 0, 3, 1'b0, r);
    check("ld_cycles", r.cycles, 8);
    check("ld_dmem_req_cycles", r.dreq, 4);
    check("ld_regwrite_cycle", r.rw_at, 8);
    check("ld_memtoreg", 32'(r.m2r), 32'd1);
    check("ld_alusrc", 32'(r.src), 32'd1);
    check("ld_dmem_we", 32'(r.we), 32'd0);

    run(32'h0030B023, 0, 0, 1'b0, r);
    check("sd_cycles", r.cycles, 4);
    check("sd_dmem_we", 32'(r.we), 32'd1);
    check("sd_no_regwrite", r.rw_at, 0);
    check("sd_aluop", 32'(r.op), 32'h2);

    run(32'h00208063, 0, 0, 1'b1, r);
    check("beq_taken_cycles", r.cycles, 3);
    check("beq_taken_pcsrc", 32'(r.pcsrc), 32'd1);
    check("beq_aluop", 32'(r.op), 32'h6);
    run(32'h00208063, 0, 0, 1'b0, r);
    check("beq_not_taken_pcsrc", 32'(r.pcsrc), 32'd0);

    // instruction memory ready exactly on the 16th request cycle
    run(32'h002081B3, 15, 0, 1'b0, r);
    check("fetch_ready_at_limit_halt", 32'(r.halt), 32'd0);
    check("fetch_ready_at_limit_cycles", r.cycles, 19);
    check("instret_after_mix", instret, 32'(exp_instret));

`ifdef CTRL_BNE_EN
    run(32'h00209063, 0, 0, 1'b0, r);
    check("bne_taken_pcsrc", 32'(r.pcsrc), 32'd1);
    check("bne_halt", 32'(r.halt), 32'd0);
`else
    run(32'h00209063, 0, 0, 1'b0, r);
    check("bne_trap_cause", 32'(r.cause), 32'd1);
    do_reset();
`endif

    // illegal opcode: trap with cause 01 and hold
    run(32'h0000107F, 0, 0, 1'b0, r);
    check("illegal_halt", 32'(r.halt), 32'd1);
    check("illegal_cycles", r.cycles, 3);
    check("illegal_cause", 32'(r.cause), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("trap_hold_outputs", 32'(all_out), 32'h0005);
    check("trap_instret_unchanged", instret, 32'(exp_instret));
    do_reset();

    run(32'h002091B3, 0, 0, 1'b0, r);
    check("rtype_bad_funct_cause", 32'(r.cause), 32'd1);
    do_reset();

    run(32'h002081B3, 100, 0, 1'b0, r);
    check("imem_timeout_cycles", r.cycles, 17);
    check("imem_timeout_cause", 32'(r.cause), 32'd2);
    do_reset();

    run(32'h0000B183, 0, 100, 1'b0, r);
    check("dmem_timeout_cycles", r.cycles, 20);
    check("dmem_timeout_cause", 32'(r.cause), 32'd3);
    do_reset();

    // reset asserted in the middle of a data access
    run(32'h002081B3, 0, 0, 1'b0, r);
    check("pre_abort_instret", instret, 32'd1);
    imem_word = 32'h0000B183;
    #1 imem_ready = 1'b1;
    @(posedge clk); #1 imem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    check("abort_in_mem", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_dmem_req_drops", 32'(dmem_req), 32'd0);
    check("abort_outputs", 32'(all_out), 32'h0);
    check("abort_instret", instret, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_instret = 0;
    #1;
    check("abort_restart_fetch", 32'(imem_req), 32'd1);
    run(32'h002081B3, 0, 0, 1'b0, r);
    check("abort_then_add_cycles", r.cycles, 4);
    check("abort_then_instret", instret, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
